// File: rtl/axis_mod_table_streamer_if.sv
// AXI4-Stream channel used by the table streamer (tvalid/tready/tdata/tlast).
interface axis_mod_table_streamer_if #(
  parameter int unsigned B = 32
) ();
  logic         tvalid;
  logic         tready;
  logic [B-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_mod_table_streamer.sv
// Table-driven AXI4-Stream frame transmitter for the modulated-DDS config port.
// A processor-loaded table of B-bit words is streamed as one frame of len words
// starting at start_addr (address wraps), with tlast on the final word.
// Optional feature: define ABORT_EN to let an abort pulse end a frame early.
module axis_mod_table_streamer #(
  parameter int unsigned B = 32,
  parameter int unsigned N = 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        wr_en,
  input  logic [N-1:0]                wr_addr,
  input  logic [B-1:0]                wr_data,
  input  logic                        start,
  input  logic [N-1:0]                start_addr,
  input  logic [N:0]                  len,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        wr_drop,
  axis_mod_table_streamer_if.master   m_axis
);

  localparam int unsigned DEPTH    = 2 ** N;
  localparam logic [N:0]   LEN_MAX  = {1'b1, {N{1'b0}}};
  localparam logic [N:0]   LEN_ONE  = {{N{1'b0}}, 1'b1};
  localparam logic [N-1:0] ADDR_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [B-1:0] mem [DEPTH];

  logic [N-1:0] iss_addr;
  logic [N:0]   iss_left;
  logic [B-1:0] rd_data;
  logic         rd_valid;
  logic         rd_last;
  logic [B-1:0] skid_data;
  logic         skid_valid;
  logic         skid_last;

  logic         launch;
  logic         issue;
  logic         accept;
  logic         out_valid;
  logic         out_last;
  logic         force_last;

`ifdef ABORT_EN
  logic         abort_q;

  // Latch an abort seen while streaming; cleared when a new frame launches.
  always_ff @(posedge aclk) begin
    if (areset) begin
      abort_q <= 1'b0;
    end else if (launch) begin
      abort_q <= 1'b0;
    end else if (state == ST_STREAM && abort) begin
      abort_q <= 1'b1;
    end
  end

  // A pending abort marks whichever beat is presented next as the last one.
  always_comb force_last = abort_q;
`else
  logic unused_abort;

  // Abort has no effect in this build.
  always_comb begin
    unused_abort = abort;
    force_last   = 1'b0;
  end
`endif

  // Datapath handshake terms: the skid entry, when occupied, is always the older beat.
  always_comb begin
    launch    = (state == ST_IDLE) && start && (len != '0);
    out_valid = (state == ST_STREAM) && (skid_valid || rd_valid);
    out_last  = (skid_valid ? skid_last : rd_last) | force_last;
    accept    = out_valid && m_axis.tready;
    issue     = ((state == ST_FETCH) || (state == ST_STREAM)) &&
                (iss_left != '0) && !skid_valid;
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (launch) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_STREAM;
      ST_STREAM: if (accept && out_last) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: status from the state, stream driven only while streaming.
  always_comb begin
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    m_axis.tvalid = out_valid;
    m_axis.tdata  = out_valid ? (skid_valid ? skid_data : rd_data) : '0;
    m_axis.tlast  = out_valid && out_last;
  end

  // Table storage and the synchronous read port; writes only while idle.
  always_ff @(posedge aclk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
    if (issue) begin
      rd_data <= mem[iss_addr];
    end
  end

  // Read-ahead/skid control: a read is issued whenever the skid slot is empty;
  // if the read register still holds an unaccepted beat it moves into the skid
  // slot, so the presented word never changes during a stall.
  always_ff @(posedge aclk) begin
    if (areset) begin
      iss_addr   <= '0;
      iss_left   <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
      wr_drop    <= 1'b0;
    end else begin
      if (wr_en && busy) begin
        wr_drop <= 1'b1;
      end
      if (launch) begin
        wr_drop  <= 1'b0;
        iss_addr <= start_addr;
        iss_left <= (len > LEN_MAX) ? LEN_MAX : len;
      end
      if ((state == ST_FETCH) || (state == ST_STREAM)) begin
        if (skid_valid) begin
          if (accept) begin
            skid_valid <= 1'b0;
          end
        end else if (issue) begin
          rd_valid <= 1'b1;
          rd_last  <= (iss_left == LEN_ONE);
          if (rd_valid && !accept) begin
            skid_valid <= 1'b1;
            skid_data  <= rd_data;
            skid_last  <= rd_last;
          end
        end else if (accept) begin
          rd_valid <= 1'b0;
        end
        if (issue) begin
          iss_addr <= iss_addr + ADDR_ONE;
          iss_left <= iss_left - LEN_ONE;
        end
      end else begin
        rd_valid   <= 1'b0;
        skid_valid <= 1'b0;
      end
    end
  end

endmodule
